alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

Iterative RV32M multiply/divide sequencer in the execute stage, beside the single-cycle ALU. The decoder asserts `start` for R-type instructions with Funct7 = 7'b0000001. While it runs, the block stalls the pipeline through `busy`. It returns one 32-bit result with a one-cycle `done` pulse. One shared radix-2 shift/add-subtract datapath handles all eight M operations.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  sole clock; rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clk`.
- `start`  in  1  request; sampled only in IDLE.
- `Funct3`  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcA`  in  WIDTH  rs1 value (multiplicand / dividend).
- `SrcB`  in  WIDTH  rs2 value (multiplier / divisor).
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `Result` valid.
- `Result`  out  WIDTH  registered result; held until the next `done`.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE, `start`=1:**
  - Capture op, sign flags and operand magnitudes.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats A as signed, B as unsigned; the U ops treat both as unsigned.
  - Clear the 6-bit counter and go to CALC.
- **Special divides (IDLE goes straight to DONE, `Result` loaded directly):**
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `SrcA`.
  - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- **CALC, one iteration per cycle for 32 cycles; counter 0..31 increments each cycle:**
  - Multiply: 64-bit shift-add of magnitudes.
  - Divide: restoring division of magnitudes using a 33-bit trial subtract. The remainder/quotient register is shifted left one bit per iteration.
  - Go to FIX when counter = 31.
- **FIX:** apply sign correction and select the output, then register it into `Result` and go to DONE.
  - Product is negated if signA ^ signB (for signed ops).
  - Quotient is negated if signA ^ signB.
  - Remainder takes the sign of the dividend.
  - MUL outputs product[31:0]; the MULH variants output product[63:32].
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- **Ignored `start`:** any `start` in CALC/FIX/DONE is ignored. It is not queued, and operands are not resampled.
- **Reset:** `reset`=0 on any edge forces IDLE with `busy`=0, `done`=0, `Result`=0, counter=0, internal registers=0. This applies mid-operation too; the aborted op never signals `done`.
- **Operand stability:** operands and `Funct3` may change after the accept cycle without effect.

## Timing
- **Reset values:** `busy`=0, `done`=0, `Result`=0.
- **Normal op latency:** `start` accepted at the edge ending cycle 0, then:
  - CALC in cycles 1–32;
  - FIX in cycle 33;
  - `done`=1 in cycle 34, with `busy`=1 in cycles 1–34.
- **Special-case latency:** `done`=1 in cycle 1.
- **Throughput:** the earliest next accept is the cycle after `done`.
- **Pipeline stall:** external stall = (`start` & ~`done`). The pipeline advances in the `done` cycle.
- **`Result` output:** changes only at the edge that enters DONE; no combinational path from inputs to outputs.

## Structure
- Package `muldiv_pkg`:
  - `muldiv_op_e` enum over the `Funct3` encodings;
  - `muldiv_state_e` enum (IDLE, CALC, FIX, DONE);
  - `MULDIV_ITER` = 32;
  - constants `DIV0_QUOT` = 32'hFFFFFFFF and `INT_MIN` = 32'h80000000.
- A single module holds the FSM plus datapath. No sub-module: the shared accumulator is simpler inline.

## Test plan
- MUL 7 × 0xFFFFFFFD → `Result`=0xFFFFFFEB, `done` pulse exactly in cycle 34, `busy` high cycles 1–34.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000;
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD;
  - REM same operands → 0xFFFFFFFF;
  - DIVU 100 / 7 → 14;
  - REMU 100 / 7 → 2.
- Special cases, each with `done` in cycle 1:
  - DIV 5/0 → 0xFFFFFFFF;
  - REMU 5/0 → 5;
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000;
  - REM same operands → 0.
- `start` re-pulsed with new operands in cycles 5 and 34 → ignored, and the first op's result is unchanged. Then `reset`=0 in cycle 10 of a new op → `busy`=0 and `Result`=0 next cycle, no `done`. A following MULHU 0xFFFFFFFF × 0xFFFFFFFF completes with 0xFFFFFFFE after 34 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_pkg : shared types and constants for the RV32M mul/div sequencer
// Revision   : 1.0
// ---------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  localparam int          MULDIV_ITER = 32;
  localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_muldiv_seq_if : request/response bundle between decode/execute and the
//                     mul/div sequencer
// Revision          : 1.0
// ---------------------------------------------------------------------------
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       Funct3;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;

  modport master (
    output start, Funct3, SrcA, SrcB,
    input  busy, done, Result
  );

  modport slave (
    input  start, Funct3, SrcA, SrcB,
    output busy, done, Result
  );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_muldiv_seq : iterative RV32M multiply/divide, one radix-2 step per cycle
// Revision       : 1.0
// ---------------------------------------------------------------------------
module alu_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic       clk,
  input  wire logic       reset,
  alu_muldiv_seq_if.slave bus
);

  muldiv_state_e      state_q, state_d;
  muldiv_op_e         op_q, op_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;

  muldiv_op_e         w_op;
  logic               w_a_signed, w_b_signed;
  logic               w_sign_a, w_sign_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic               w_div0, w_ovf;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_trial;
  logic               w_fits;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem;

  assign w_op       = muldiv_op_e'(bus.Funct3);
  assign w_a_signed = bus.Funct3[2] ? ~bus.Funct3[0] : (bus.Funct3 != 3'b011);
  assign w_b_signed = bus.Funct3[2] ? ~bus.Funct3[0] : ~bus.Funct3[1];
  assign w_sign_a   = w_a_signed & bus.SrcA[WIDTH-1];
  assign w_sign_b   = w_b_signed & bus.SrcB[WIDTH-1];
  assign w_mag_a    = cond_neg32(bus.SrcA, w_sign_a);
  assign w_mag_b    = cond_neg32(bus.SrcB, w_sign_b);

  assign w_div0 = bus.Funct3[2] && (bus.SrcB == '0);
  assign w_ovf  = bus.Funct3[2] && !bus.Funct3[0] &&
                  (bus.SrcA == INT_MIN) && (bus.SrcB == DIV0_QUOT);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

  // Divide: acc = {remainder, dividend/quotient}, shifted left; 33-bit trial compare.
  assign w_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_fits   = (w_rem_sh >= {1'b0, opb_q});
  assign w_trial  = w_rem_sh[WIDTH-1:0] - opb_q;

  assign w_prod = (neg_a_q ^ neg_b_q) ? (~acc_q + 64'd1) : acc_q;
  assign w_quot = cond_neg32(acc_q[WIDTH-1:0], neg_a_q ^ neg_b_q);
  assign w_rem  = cond_neg32(acc_q[2*WIDTH-1:WIDTH], neg_a_q);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    cnt_d    = cnt_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = w_op;
          neg_a_d = w_sign_a;
          neg_b_d = w_sign_b;
          cnt_d   = '0;
          opb_d   = w_mag_b;
          acc_d   = {{WIDTH{1'b0}}, w_mag_a};
          if (w_div0) begin
            result_d = bus.Funct3[1] ? bus.SrcA : DIV0_QUOT;
            state_d  = ST_DONE;
          end else if (w_ovf) begin
            result_d = bus.Funct3[1] ? '0 : INT_MIN;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (op_q[2]) begin
          acc_d = {(w_fits ? w_trial : w_rem_sh[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], w_fits};
        end else begin
          acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MULDIV_ITER - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        case (op_q)
          OP_MUL:                      result_d = w_prod[WIDTH-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = w_prod[2*WIDTH-1:WIDTH];
          OP_DIV, OP_DIVU:             result_d = w_quot;
          default:                     result_d = w_rem;
        endcase
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      cnt_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      cnt_q    <= cnt_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.Result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_muldiv_seq : directed self-checking bench for alu_muldiv_seq
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_alu_muldiv_seq;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  alu_muldiv_seq_if #(.WIDTH(32)) bus ();

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op at cycle 0 and observe cycles 1..lat+3; operands are scrambled
  // after the accept cycle so any resampling would corrupt the result.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int lat, output int done_cyc, output int done_cnt,
                       output logic [31:0] res, output bit busy_ok);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Funct3 = f3;
    bus.SrcA   = a;
    bus.SrcB   = b;
    done_cyc = -1;
    done_cnt = 0;
    busy_ok  = 1'b1;
    res      = 32'hDEAD_BEEF;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      bus.start  = 1'b0;
      bus.SrcA   = $urandom;
      bus.SrcB   = $urandom;
      bus.Funct3 = 3'($urandom);
      if (bus.busy !== (k <= lat)) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k;
          res      = bus.Result;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.Funct3 = 3'b000;
    bus.SrcA  = '0;
    bus.SrcB  = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else n_pass++;
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done); else n_pass++;
    n_total++;
    if (bus.Result !== 32'h0) $display("FAIL reset_result got=%h want=00000000", bus.Result); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int dc, cnt;
    logic [31:0] r;
    bit bok;
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 34, dc, cnt, r, bok);
    n_total++;
    if (r !== 32'hFFFF_FFEB) $display("FAIL mul_result got=%h want=ffffffeb", r); else n_pass++;
    n_total++;
    if (dc !== 34) $display("FAIL mul_done_cycle got=%0d want=34", dc); else n_pass++;
    n_total++;
    if (cnt !== 1) $display("FAIL mul_done_count got=%0d want=1", cnt); else n_pass++;
    n_total++;
    if (bok !== 1'b1) $display("FAIL mul_busy_window got=%b want=1", bok); else n_pass++;
    n_total++;
    if (bus.Result !== 32'hFFFF_FFEB) $display("FAIL mul_result_held got=%h want=ffffffeb", bus.Result); else n_pass++;
  endtask

  task automatic test_mulh();
    logic [2:0]  f3  [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] a   [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b   [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int dc, cnt;
    logic [31:0] r;
    bit bok;
    for (int i = 0; i < 3; i++) begin
      do_op(f3[i], a[i], b[i], 34, dc, cnt, r, bok);
      n_total++;
      if (r !== exp[i]) $display("FAIL mulh_result[%0d] got=%h want=%h", i, r, exp[i]); else n_pass++;
      n_total++;
      if (dc !== 34 || cnt !== 1) $display("FAIL mulh_done[%0d] got cyc=%0d cnt=%0d want cyc=34 cnt=1", i, dc, cnt); else n_pass++;
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] a   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int dc, cnt;
    logic [31:0] r;
    bit bok;
    for (int i = 0; i < 4; i++) begin
      do_op(f3[i], a[i], b[i], 34, dc, cnt, r, bok);
      n_total++;
      if (r !== exp[i]) $display("FAIL div_result[%0d] got=%h want=%h", i, r, exp[i]); else n_pass++;
      n_total++;
      if (dc !== 34 || cnt !== 1 || !bok) $display("FAIL div_timing[%0d] got cyc=%0d cnt=%0d busy_ok=%b want 34/1/1", i, dc, cnt, bok); else n_pass++;
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3  [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] a   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    int dc, cnt;
    logic [31:0] r;
    bit bok;
    for (int i = 0; i < 4; i++) begin
      do_op(f3[i], a[i], b[i], 1, dc, cnt, r, bok);
      n_total++;
      if (r !== exp[i]) $display("FAIL special_result[%0d] got=%h want=%h", i, r, exp[i]); else n_pass++;
      n_total++;
      if (dc !== 1) $display("FAIL special_done_cycle[%0d] got=%0d want=1", i, dc); else n_pass++;
      n_total++;
      if (cnt !== 1 || !bok) $display("FAIL special_busy[%0d] got cnt=%0d busy_ok=%b want 1/1", i, cnt, bok); else n_pass++;
    end
  endtask

  task automatic test_ignore_start();
    int dc = -1;
    int cnt = 0;
    logic [31:0] r = 32'hDEAD_BEEF;
    logic busy36 = 1'b1;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Funct3 = 3'b000;
    bus.SrcA   = 32'd7;
    bus.SrcB   = 32'hFFFF_FFFD;
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cnt++;
        if (dc < 0) begin
          dc = k;
          r  = bus.Result;
        end
      end
      if (k == 36) busy36 = bus.busy;
      bus.start  = (k == 5 || k == 34);
      bus.Funct3 = 3'b100;
      bus.SrcA   = 32'h1234_5678;
      bus.SrcB   = 32'd3;
    end
    n_total++;
    if (r !== 32'hFFFF_FFEB) $display("FAIL ignore_result got=%h want=ffffffeb", r); else n_pass++;
    n_total++;
    if (dc !== 34 || cnt !== 1) $display("FAIL ignore_done got cyc=%0d cnt=%0d want cyc=34 cnt=1", dc, cnt); else n_pass++;
    n_total++;
    if (busy36 !== 1'b0) $display("FAIL ignore_not_queued got busy=%b want=0", busy36); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int cnt = 0;
    int dc, dcnt;
    logic [31:0] r;
    bit bok;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Funct3 = 3'b101;
    bus.SrcA   = 32'd100;
    bus.SrcB   = 32'd7;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 10) reset = 1'b0;
    end
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", bus.busy); else n_pass++;
    n_total++;
    if (bus.Result !== 32'h0) $display("FAIL abort_result got=%h want=00000000", bus.Result); else n_pass++;
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL abort_done got=%b want=0", bus.done); else n_pass++;
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) cnt++;
    end
    n_total++;
    if (cnt !== 0) $display("FAIL abort_no_done got=%0d want=0", cnt); else n_pass++;
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, dc, dcnt, r, bok);
    n_total++;
    if (r !== 32'hFFFF_FFFE) $display("FAIL post_abort_result got=%h want=fffffffe", r); else n_pass++;
    n_total++;
    if (dc !== 34 || dcnt !== 1 || !bok) $display("FAIL post_abort_timing got cyc=%0d cnt=%0d busy_ok=%b want 34/1/1", dc, dcnt, bok); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_ignore_start();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
